// File: rtl/load_align_unit.sv
// Load-side byte-lane aligner: issues a word-aligned read, then extracts and
// extends the addressed byte/half/word into one registered result per request.
module load_align_unit #(
   parameter int TIMEOUT = 16,
   parameter int CW      = 5
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        LD_VALID,
   output logic        LD_READY,
   input  logic [31:0] ADDR,
   input  logic [2:0]  FUNCT3,
   output logic        MEM_REQ,
   output logic [31:0] MEM_ADDR,
   input  logic        MEM_ACK,
   input  logic [31:0] MEM_RDATA,
   output logic        RES_VALID,
   output logic [31:0] RES_DATA,
   output logic        ERR
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic [1:0]    k;
   logic [2:0]    f3;
   logic          bad;
   logic [31:0]   shifted;
   logic [31:0]   ext;

   assign LD_READY = (state == IDLE);

   always_comb begin
      bad = 1'b0;
      case (FUNCT3)
         3'b000, 3'b100: bad = 1'b0;
         3'b001, 3'b101: bad = ADDR[0];
         3'b010:         bad = |ADDR[1:0];
         default:        bad = 1'b1;
      endcase
   end

   // LW is always aligned (k=0), so the shifted word doubles as the LW result.
   assign shifted = MEM_RDATA >> {k, 3'b000};

   always_comb begin
      ext = shifted;
      case (f3)
         3'b000:  ext = {{24{shifted[7]}}, shifted[7:0]};
         3'b100:  ext = {24'd0, shifted[7:0]};
         3'b001:  ext = {{16{shifted[15]}}, shifted[15:0]};
         3'b101:  ext = {16'd0, shifted[15:0]};
         default: ext = shifted;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= IDLE;
         MEM_REQ   <= 1'b0;
         MEM_ADDR  <= 32'd0;
         RES_VALID <= 1'b0;
         RES_DATA  <= 32'd0;
         ERR       <= 1'b0;
         cnt       <= '0;
         k         <= 2'd0;
         f3        <= 3'd0;
      end else begin
         case (state)
            IDLE: begin
               if (LD_VALID) begin
                  k  <= ADDR[1:0];
                  f3 <= FUNCT3;
                  if (bad) begin
                     RES_DATA  <= 32'd0;
                     ERR       <= 1'b1;
                     RES_VALID <= 1'b1;
                     state     <= DONE;
                  end else begin
                     MEM_REQ  <= 1'b1;
                     MEM_ADDR <= {ADDR[31:2], 2'b00};
                     cnt      <= '0;
                     state    <= WAIT;
                  end
               end
            end
            WAIT: begin
               // An ack on the limit edge still completes the load normally.
               if (MEM_ACK) begin
                  MEM_REQ   <= 1'b0;
                  RES_DATA  <= ext;
                  ERR       <= 1'b0;
                  RES_VALID <= 1'b1;
                  state     <= DONE;
               end else if (cnt == CW'(TIMEOUT - 1)) begin
                  MEM_REQ   <= 1'b0;
                  RES_DATA  <= 32'd0;
                  ERR       <= 1'b1;
                  RES_VALID <= 1'b1;
                  state     <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               RES_VALID <= 1'b0;
               ERR       <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
